// File: rtl/instr_encoder_pkg.sv
// legv8_pkg: LEGv8 instruction kinds, opcodes and field widths shared by encoder and decoder
package legv8_pkg;
  localparam int WORD_W = 32;
  localparam int KIND_W = 3;
  localparam int REG_W = 5;
  localparam int IMM_W = 19;
  localparam int DT_W = 9;
  localparam int OPC_W = 11;
  localparam int CBOPC_W = 8;
  typedef enum logic [KIND_W-1:0] {
    K_ADD, K_SUB, K_AND, K_ORR, K_LDUR, K_STUR, K_CBZ, K_ILL
  } instr_kind_t;
  localparam logic [OPC_W-1:0] OP_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [CBOPC_W-1:0] OP_CBZ = 8'b10110100;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: symbolic instruction handshake plus instruction-memory write port
interface instr_encoder_if import legv8_pkg::*; #(parameter int ADDR_W = 6);
  logic in_valid;
  logic in_ready;
  logic [KIND_W-1:0] in_kind;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_rn;
  logic [REG_W-1:0] in_rm;
  logic [IMM_W-1:0] in_imm;
  logic imem_hold;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  modport master (
    output in_valid, in_kind, in_rd, in_rn, in_rm, in_imm, imem_hold,
    input in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input in_valid, in_kind, in_rd, in_rn, in_rm, in_imm, imem_hold,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with full/empty/count and active-low sync reset
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [PW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  // Storage needs no reset: the head is only consumed while count is nonzero
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + PW'(1);
      if (rd) rp <= rp + PW'(1);
      count <= count + (PW+1)'(wr) - (PW+1)'(rd);
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes symbolic LEGv8 instructions and streams them into instruction memory
module instr_encoder import legv8_pkg::*; #(
  parameter int IMEM_DEPTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic clk,
  input  logic reset,
  instr_encoder_if.slave bus,
  output logic [ADDR_W:0] word_count,
  output logic wrapped,
  output logic err_illegal
);
  instr_kind_t kind;
  logic [OPC_W-1:0] r_op;
  logic [WORD_W-1:0] word, head;
  logic [$clog2(FIFO_DEPTH):0] occ;
  logic full, empty, xfer, push, pop;
  logic [ADDR_W-1:0] ptr;
  assign kind = instr_kind_t'(bus.in_kind);
  // Combinational encoder from the presented fields; illegal kinds are never pushed
  always_comb begin
    r_op = kind == K_ADD ? OP_ADD : kind == K_SUB ? OP_SUB : kind == K_AND ? OP_AND : OP_ORR;
    word = kind <= K_ORR ? {r_op, bus.in_rm, 6'b0, bus.in_rn, bus.in_rd}
         : kind == K_CBZ ? {OP_CBZ, bus.in_imm, bus.in_rd}
         : {kind == K_LDUR ? OP_LDUR : OP_STUR, bus.in_imm[DT_W-1:0], 2'b00, bus.in_rn, bus.in_rd};
  end
  assign bus.in_ready = reset && !full;
  assign xfer = bus.in_valid && bus.in_ready;
  assign push = xfer && kind != K_ILL;
  assign pop = reset && occ != '0 && !bus.imem_hold;
  assign bus.imem_we = pop;
  assign bus.imem_wdata = (reset && !empty) ? head : '0;
  assign bus.imem_addr = ptr;
  sync_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(word),
    .dout(head), .full(full), .empty(empty), .count(occ)
  );
  // Write pointer, saturating word counter and sticky status flags
  always_ff @(posedge clk)
    if (!reset) begin
      ptr <= '0;
      word_count <= '0;
      wrapped <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (pop) begin
        ptr <= ptr + ADDR_W'(1);
        if (&ptr) wrapped <= 1'b1;
        if (word_count != (ADDR_W+1)'(IMEM_DEPTH)) word_count <= word_count + (ADDR_W+1)'(1);
      end
      if (xfer && kind == K_ILL) err_illegal <= 1'b1;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue-based reference model checked every cycle
module tb_instr_encoder;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int FD = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW:0] word_count;
  logic wrapped, err_illegal;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  instr_encoder_if #(.ADDR_W(AW)) bus();
  instr_encoder #(.IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .word_count(word_count), .wrapped(wrapped), .err_illegal(err_illegal)
  );
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [31:0] enc(int k, int rd, int rn, int rm, int imm);
    longint op[6] = '{1112, 1624, 1104, 1360, 1986, 1984};
    longint cb = 180;
    if (k < 4) return 32'(op[k] * (2**21) + rm * 65536 + rn * 32 + rd);
    if (k < 6) return 32'(op[k] * (2**21) + (imm % 512) * 4096 + rn * 32 + rd);
    return 32'(cb * (2**24) + longint'(imm) * 32 + rd);
  endfunction
  logic [31:0] q[$];
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_wrap = 0;
  bit m_err = 0;
  bit m_rdy, m_we;
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_ptr = 0;
      m_cnt = 0;
      m_wrap = 0;
      m_err = 0;
    end else begin
      m_rdy = q.size() < FD;
      m_we = q.size() > 0 && !bus.imem_hold;
      if (m_we) begin
        void'(q.pop_front());
        if (m_ptr == DEPTH - 1) m_wrap = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
      end
      if (bus.in_valid && m_rdy) begin
        if (bus.in_kind == 3'd7) m_err = 1;
        else q.push_back(enc(int'(bus.in_kind), int'(bus.in_rd), int'(bus.in_rn), int'(bus.in_rm), int'(bus.in_imm)));
      end
    end
  end
  always @(negedge clk) begin
    check("in_ready", bus.in_ready, reset && q.size() < FD);
    check("imem_we", bus.imem_we, reset && q.size() > 0 && !bus.imem_hold);
    check("imem_wdata", bus.imem_wdata, (reset && q.size() > 0) ? q[0] : 0);
    check("imem_addr", bus.imem_addr, m_ptr);
    check("word_count", word_count, m_cnt);
    check("wrapped", wrapped, m_wrap);
    check("err_illegal", err_illegal, m_err);
  end
  int log_a[$];
  logic [31:0] log_d[$];
  always @(negedge clk)
    if (bus.imem_we === 1'b1) begin
      log_a.push_back(int'(bus.imem_addr));
      log_d.push_back(bus.imem_wdata);
    end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.imem_hold = 1'b0;
    tick(2);
    reset = 1'b1;
    log_a.delete();
    log_d.delete();
  endtask
  task automatic send(int k, int rd, int rn, int rm, int imm, int budget, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_kind = 3'(k);
    bus.in_rd = 5'(rd);
    bus.in_rn = 5'(rn);
    bus.in_rm = 5'(rm);
    bus.in_imm = 19'(imm);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic put(int k, int rd, int rn, int rm, int imm);
    bit ok;
    send(k, rd, rn, rm, imm, 20, ok);
    check("accept", ok, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_rd = '0;
    bus.in_rn = '0;
    bus.in_rm = '0;
    bus.in_imm = '0;
    bus.imem_hold = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_count", word_count, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.in_ready, 1);
    tick(1);
    put(0, 3, 1, 2, 0);
    @(negedge clk);
    check("add_we", bus.imem_we, 1);
    check("add_addr", bus.imem_addr, 0);
    check("add_wdata", bus.imem_wdata, 32'h8B020023);
    tick(1);
    do_reset();
    put(4, 5, 6, 0, 8);
    put(5, 5, 6, 0, 16);
    tick(3);
    check("dt_writes", log_a.size(), 2);
    check("ldur_addr", log_a[0], 0);
    check("ldur_wdata", log_d[0], 32'hF84080C5);
    check("stur_addr", log_a[1], 1);
    check("stur_wdata", log_d[1], 32'hF80100C5);
    check("dt_count", word_count, 2);
    do_reset();
    put(6, 7, 31, 17, 5);
    put(1, 9, 10, 11, 0);
    put(4, 5, 6, 31, 19'h7FE08);
    put(2, 1, 2, 3, 0);
    put(3, 31, 30, 29, 0);
    put(6, 0, 0, 0, 19'h7FFFF);
    tick(3);
    check("cbz_wdata", log_d[0], 32'hB40000A7);
    check("sub_wdata", log_d[1], 32'hCB0B0149);
    check("ldur_hi_imm", log_d[2], 32'hF84080C5);
    do_reset();
    bus.imem_hold = 1'b1;
    for (int i = 0; i < 4; i++) put(0, i, i, i, 0);
    send(0, 4, 4, 4, 0, 3, ok);
    check("held_5th_accept", ok, 0);
    check("held_ready", bus.in_ready, 0);
    check("held_writes", log_a.size(), 0);
    bus.imem_hold = 1'b0;
    put(0, 4, 4, 4, 0);
    put(0, 5, 5, 5, 0);
    tick(4);
    check("hold_writes", log_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("hold_addr", log_a[i], i);
      check("hold_wdata", log_d[i], 32'h8B000000 | (i << 16) | (i << 5) | i);
    end
    do_reset();
    put(0, 1, 2, 3, 0);
    put(7, 1, 1, 1, 1);
    put(0, 4, 5, 6, 0);
    tick(3);
    check("ill_err", err_illegal, 1);
    check("ill_writes", log_a.size(), 2);
    check("ill_addr0", log_a[0], 0);
    check("ill_addr1", log_a[1], 1);
    bus.imem_hold = 1'b1;
    put(0, 1, 1, 1, 0);
    put(0, 2, 2, 2, 0);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("mid_rst_we", bus.imem_we, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    check("mid_rst_addr", bus.imem_addr, 0);
    check("mid_rst_count", word_count, 0);
    check("mid_rst_err", err_illegal, 0);
    check("mid_rst_wrap", wrapped, 0);
    tick(1);
    reset = 1'b1;
    bus.imem_hold = 1'b0;
    @(negedge clk);
    check("post_rst_we", bus.imem_we, 0);
    tick(1);
    do_reset();
    for (int i = 0; i <= DEPTH; i++) put(0, i % 32, 1, 2, 0);
    tick(3);
    check("wrap_writes", log_a.size(), DEPTH + 1);
    check("wrap_last_addr", log_a[DEPTH], 0);
    check("wrap_flag", wrapped, 1);
    check("wrap_count", word_count, DEPTH);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
